ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the instruction-memory word-address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the fetch address loaded at reset.
REQ-003 clock_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 imem_addr_o  output  ADDR_W  SHALL be the word address to the synchronous instruction memory.
REQ-006 imem_instr_i  input  32  SHALL be the memory read data, valid one cycle after the address.
REQ-007 redirect_i  input  1  SHALL request a fetch restart (branch/jump/trap).
REQ-008 redirect_pc_i  input  32  SHALL be the byte address to restart from.
REQ-009 valid_o  output  1  SHALL flag that instr_o/pc_o hold a fetched instruction.
REQ-010 ready_i  input  1  SHALL flag that the decode stage accepts instr_o this cycle.
REQ-011 instr_o  output  32  SHALL be the fetched instruction word.
REQ-012 pc_o  output  32  SHALL be the byte address of instr_o.
REQ-013 perf_fetch_o, perf_stall_o  output  32 each  SHALL be performance counters (see Configuration).

Function
REQ-014 State: pc_q (next fetch PC), inflight_q, inflight_pc_q, 2-entry FIFO of {instr, pc}, count 0..2.
REQ-015 imem_addr_o SHALL equal pc_q[ADDR_W+1:2], driven from registers only; no combinational path from ready_i or redirect_i.
REQ-016 push = inflight_q && !redirect_i; push writes {imem_instr_i, inflight_pc_q} into the FIFO.
REQ-017 valid_o = (count != 0); instr_o/pc_o SHALL show the FIFO head; pop = valid_o && ready_i.
REQ-018 issue SHALL be asserted iff (count - pop + push) <= 1 and !redirect_i; never more than 2 words buffered plus in flight.
REQ-019 On issue: inflight_q<=1, inflight_pc_q<=pc_q, pc_q<=pc_q+4 (modulo 2^32); otherwise inflight_q<=0, pc_q holds.
REQ-020 Word index wraps naturally at 4*2^ADDR_W bytes; no error is raised.
REQ-021 On redirect_i: FIFO flushed (count<=0), inflight_q<=0, pc_q<=redirect_pc_i with bits [1:0] forced to 0.
REQ-022 Redirect priority: a pop completing in the redirect cycle SHALL count as consumed; the in-flight word SHALL be dropped.
REQ-023 Latency: first valid_o SHALL occur 2 cycles after reset release or after the redirect cycle.
REQ-024 Throughput: with ready_i held high, one instruction per cycle at consecutive PCs.
REQ-025 Backpressure: instr_o/pc_o SHALL hold stable while valid_o && !ready_i; no word lost or duplicated.
REQ-026 Simultaneous push and pop at count 2 is impossible by REQ-018; at count 1 count stays 1.

Reset
REQ-027 While reset_ni=0: pc_q=RESET_PC, inflight_q=0, count=0, valid_o=0, instr_o=0, pc_o=0, counters=0.
REQ-028 Reset asserted mid-operation SHALL clear all state immediately, regardless of clock.

Configuration
REQ-029 Macro IFETCH_PERF_EN, when defined, SHALL compile in perf_fetch_o (increments on each pop) and perf_stall_o (increments each cycle valid_o && !ready_i), both saturating at 32'hFFFF_FFFF.
REQ-030 Without IFETCH_PERF_EN, both ports SHALL remain present and be tied to 0; no counter logic.

Verification
REQ-031 Reset release, RESET_PC=0, ready_i=1 -> imem_addr_o 0,1,2,...; valid_o first high cycle 2 with pc_o=0, then pc_o=4,8,12 every cycle.
REQ-032 ready_i low for 5 cycles in steady stream at pc_o=0x10 -> instr_o/pc_o held at 0x10, count reaches 2, issue stops; after ready_i high, pc_o 0x10,0x14,0x18 with no gaps or repeats.
REQ-033 redirect_i with redirect_pc_i=0x203 while FIFO full -> valid_o low next cycle, imem_addr_o=0x80, valid_o high 2 cycles after with pc_o=0x200.
REQ-034 Redirect to 0xFFC (ADDR_W=10) -> pc_o 0xFFC then 0x1000, imem_addr_o 0x3FF then 0x000.
REQ-035 reset_ni pulsed low between clock edges mid-stream -> valid_o and count 0 immediately; restart from RESET_PC per REQ-031.
REQ-036 With IFETCH_PERF_EN: 10 accepted words and 3 stall cycles -> perf_fetch_o=10, perf_stall_o=3; without macro both read 0.

Source files
------------

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end for a synchronous instruction memory.
// One word is requested per cycle. Fetched words land in a 2-entry {instr, pc}
// skid FIFO that feeds decode through a valid/ready handshake. A redirect
// flushes the FIFO, drops the word in flight and restarts fetch.
// Optional feature macro: IFETCH_PERF_EN compiles in saturating fetch/stall
// performance counters. Without it both counter ports read zero.
module ifetch_unit #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_instr_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       instr_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       perf_fetch_o,
  output logic [31:0]       perf_stall_o
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_q, rd_d;
  entry_t      fifo_q [2];

  logic        push, pop, issue, wr_idx;
  logic [2:0]  occ;

  // The memory sees only the registered PC, so ready/redirect never reach
  // the address pins combinationally.
  assign imem_addr_o = pc_q[ADDR_W+1:2];

  assign valid_o = (count_q != 2'd0);
  assign instr_o = fifo_q[rd_q].instr;
  assign pc_o    = fifo_q[rd_q].pc;

  assign push   = inflight_q && !redirect_i;
  assign pop    = valid_o && ready_i;
  // pop implies count >= 1, so the occupancy never goes negative.
  assign occ    = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};
  // Only issue when the returning word is guaranteed a free FIFO slot.
  assign issue  = (occ <= 3'd1) && !redirect_i;
  // Tail slot sits one past the head when a word is already buffered.
  assign wr_idx = rd_q ^ count_q[0];

  // Next-state for fetch PC, in-flight tracking and FIFO pointers.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = occ[1:0];
    rd_d          = rd_q ^ pop;
    if (redirect_i) begin
      // A pop in this cycle is consumed; the in-flight word is discarded.
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      count_d = 2'd0;
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + 32'd4;
    end
  end

  // Control state register.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      count_q       <= 2'd0;
      rd_q          <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_q          <= rd_d;
    end
  end

  // FIFO storage; cleared on reset so instr_o/pc_o read zero while idle.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (push) begin
      fifo_q[wr_idx] <= '{instr: imem_instr_i, pc: inflight_pc_q};
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  // Saturating counters: accepted words and backpressured cycles.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (pop && (perf_fetch_q != 32'hFFFF_FFFF))
        perf_fetch_q <= perf_fetch_q + 32'd1;
      if (valid_o && !ready_i && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_fetch_o = 32'd0;
  assign perf_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: self-checking bench for ifetch_unit with a synchronous
// instruction memory model and a stream-level reference model.
module tb_ifetch_unit;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_instr = 32'd0;
  logic          redirect = 1'b0;
  logic [31:0]   rpc = 32'd0;
  logic          valid;
  logic          ready = 1'b1;
  logic [31:0]   instr, pc, perf_fetch, perf_stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
    .clock_i(clk), .reset_ni(rst_n), .imem_addr_o(imem_addr),
    .imem_instr_i(imem_instr), .redirect_i(redirect), .redirect_pc_i(rpc),
    .valid_o(valid), .ready_i(ready), .instr_o(instr), .pc_o(pc),
    .perf_fetch_o(perf_fetch), .perf_stall_o(perf_stall)
  );

  // Memory contents: a distinct word per index.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h600D_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] p);
    return mem_word(p[AW+1:2]);
  endfunction

  always @(posedge clk) imem_instr <= mem_word(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after reset release, before the first negedge of cycle 0.
  task automatic startup_seq(input string tag);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk({tag, "_addr"}, 32'(imem_addr), 32'(c));
      chk({tag, "_valid"}, 32'(valid), 32'(c >= 2));
      if (c >= 2) begin
        chk({tag, "_pc"}, pc, 32'(4 * (c - 2)));
        chk({tag, "_instr"}, instr, word_at(32'(4 * (c - 2))));
      end
    end
  endtask

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] addr1, addr2, pc1, pc2;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a1;
    logic [31:0]   exp_pc, exp_fetch, exp_stall;
    int            pops, stalls, nred;
    bit            found, done;

    vecs[0] = '{rpc: 32'h0000_0203, addr1: 32'h080, addr2: 32'h081, pc1: 32'h0000_0200, pc2: 32'h0000_0204};
    vecs[1] = '{rpc: 32'h0000_0FFC, addr1: 32'h3FF, addr2: 32'h000, pc1: 32'h0000_0FFC, pc2: 32'h0000_1000};
    vecs[2] = '{rpc: 32'hFFFF_FFFE, addr1: 32'h3FF, addr2: 32'h000, pc1: 32'hFFFF_FFFC, pc2: 32'h0000_0000};
    vecs[3] = '{rpc: 32'h0000_1006, addr1: 32'h001, addr2: 32'h002, pc1: 32'h0000_1004, pc2: 32'h0000_1008};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_perf_fetch", perf_fetch, 32'd0);
    chk("rst_perf_stall", perf_stall, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    startup_seq("start");

    // Backpressure at pc 0x10.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (valid && pc == 32'h10) found = 1'b1;
      else @(negedge clk);
    end
    chk("bp_reach_0x10", 32'(found), 32'd1);
    ready = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      @(negedge clk);
      chk("bp_valid", 32'(valid), 32'd1);
      chk("bp_pc_hold", pc, 32'h10);
      chk("bp_instr_hold", instr, word_at(32'h10));
      if (s == 1) a1 = imem_addr;
      else chk("bp_issue_stopped", 32'(imem_addr), 32'(a1));
    end
    ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(negedge clk);
      chk("bp_resume_valid", 32'(valid), 32'd1);
      chk("bp_resume_pc", pc, 32'h10 + 32'(4 * j));
    end

    // Redirect table, each applied with a full FIFO.
    foreach (vecs[i]) begin
      ready = 1'b0;
      repeat (3) @(negedge clk);
      redirect = 1'b1;
      rpc = vecs[i].rpc;
      @(negedge clk);
      redirect = 1'b0;
      ready = 1'b1;
      chk("rd_valid_n1", 32'(valid), 32'd0);
      chk("rd_addr_n1", 32'(imem_addr), vecs[i].addr1);
      @(negedge clk);
      chk("rd_valid_n2", 32'(valid), 32'd0);
      chk("rd_addr_n2", 32'(imem_addr), vecs[i].addr2);
      @(negedge clk);
      chk("rd_valid_n3", 32'(valid), 32'd1);
      chk("rd_pc1", pc, vecs[i].pc1);
      chk("rd_instr1", instr, word_at(vecs[i].pc1));
      @(negedge clk);
      chk("rd_pc2", pc, vecs[i].pc2);
      chk("rd_instr2", instr, word_at(vecs[i].pc2));
    end

    // Asynchronous reset pulse between clock edges mid-stream.
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_pc", pc, 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    #1 rst_n = 1'b1;
    startup_seq("restart");

    // Performance counters: 10 accepted words, 3 stall cycles.
    @(posedge clk); #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    pops = 0; stalls = 0; done = 1'b0;
    ready = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (pops == 10 && stalls == 3) begin
`ifdef IFETCH_PERF_EN
        exp_fetch = 32'd10; exp_stall = 32'd3;
`else
        exp_fetch = 32'd0;  exp_stall = 32'd0;
`endif
        chk("perf_fetch", perf_fetch, exp_fetch);
        chk("perf_stall", perf_stall, exp_stall);
        done = 1'b1;
        ready = 1'b0;
      end else begin
        ready = !(valid && pops >= 4 && stalls < 3);
        if (valid && ready) pops++;
        if (valid && !ready) stalls++;
      end
    end
    chk("perf_reached", 32'(done), 32'd1);

    // Randomized stream against the reference model.
    @(negedge clk);
    redirect = 1'b1; rpc = $urandom; ready = 1'b1;
    exp_pc = {rpc[31:2], 2'b00};
    nred = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (nred >= 0) begin
        nred++;
        if (nred <= 2) chk("rnd_latency_low", 32'(valid), 32'd0);
        else begin
          chk("rnd_latency_high", 32'(valid), 32'd1);
          nred = -1;
        end
      end
      if (valid) begin
        chk("rnd_pc", pc, exp_pc);
        chk("rnd_instr", instr, word_at(exp_pc));
      end
      redirect = ($urandom_range(19) == 0);
      ready = ($urandom_range(3) != 0);
      rpc = $urandom;
      if (valid && ready) exp_pc += 32'd4;
      if (redirect) begin
        exp_pc = {rpc[31:2], 2'b00};
        nred = 0;
      end
    end
    redirect = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
